ram_256x8_fifo_ctrl: RTL and testbench



---
 rtl/ram_256x8_fifo_ctrl_if.sv | 33 +++
 rtl/ram_256x8_fifo_ctrl.sv | 118 +++++++++++
 tb/tb_ram_256x8_fifo_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_256x8_fifo_ctrl_if.sv
// Requester, RAM-bank and power-handshake signals of the 256x8 FIFO controller.
// The controller takes the slave view; the requester/bench side takes the master view.
interface ram_256x8_fifo_ctrl_if;
    logic       wr_pvld;
    logic       wr_prdy;
    logic [7:0] wr_pd;
    logic       rd_pvld;
    logic       rd_prdy;
    logic [7:0] rd_pd;
    logic       ram_re;
    logic [7:0] ram_ra;
    logic       ram_we;
    logic [7:0] ram_wa;
    logic [7:0] ram_wd;
    logic [7:0] ram_rd;
    logic [7:0] ram_sleep_en;
    logic       ram_ret_en;
    logic       pwr_sleep_req;
    logic       pwr_sleep_ack;
    logic [8:0] ram_count;

    modport master (
        output wr_pvld, wr_pd, rd_prdy, ram_rd, pwr_sleep_req,
        input  wr_prdy, rd_pvld, rd_pd, ram_re, ram_ra, ram_we, ram_wa, ram_wd,
               ram_sleep_en, ram_ret_en, pwr_sleep_ack, ram_count
    );

    modport slave (
        input  wr_pvld, wr_pd, rd_prdy, ram_rd, pwr_sleep_req,
        output wr_prdy, rd_pvld, rd_pd, ram_re, ram_ra, ram_we, ram_wa, ram_wd,
               ram_sleep_en, ram_ret_en, pwr_sleep_ack, ram_count
    );
endinterface

// File: rtl/ram_256x8_fifo_ctrl.sv
// FIFO controller for one 256x8 dual-port RAM bank with a 2-entry output buffer
// and a run/drain/retention/wake power sequencer.
module ram_256x8_fifo_ctrl #(
    parameter int WAKE_CYC = 2
) (
    input  logic                         nvdla_core_clk,
    input  logic                         nvdla_core_rstn,
    ram_256x8_fifo_ctrl_if.slave         bus
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_RET   = 2'd2;
    localparam logic [1:0] ST_WAKE  = 2'd3;

    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic [7:0] wptr_reg;
    logic [7:0] rptr_reg;
    logic [8:0] count_reg;
    logic [8:0] count_next;
    logic       inflight_reg;
    logic [1:0] out_cnt_reg;
    logic [1:0] out_cnt_next;
    logic       out_head_reg;
    logic [3:0] wake_cnt_reg;
    logic       wr_prdy_reg;

    logic       push;
    logic       pop;
    logic       issue;
    logic       capture;
    logic       wake_done;
    logic       buf_wr_idx;
    logic [1:0] occupancy;
    logic [7:0] buf_data [2];

    assign pop       = (out_cnt_reg != 2'd0) && bus.rd_prdy;
    assign push      = bus.wr_pvld && wr_prdy_reg && (state_reg == ST_RUN);
    assign capture   = inflight_reg;
    assign occupancy = out_cnt_reg + {1'b0, inflight_reg};

    // Only issue when the landing slot is guaranteed: a pop this cycle frees one.
    assign issue = (state_reg == ST_RUN) && (count_reg != 9'd0) &&
                   ((occupancy < 2'd2) || ((occupancy == 2'd2) && pop));

    assign count_next   = count_reg + {8'd0, push} - {8'd0, issue};
    assign out_cnt_next = out_cnt_reg + {1'b0, capture} - {1'b0, pop};
    assign wake_done    = (wake_cnt_reg == 4'(WAKE_CYC - 1));

    // Capture slot is the one just behind the current tail of the buffer.
    assign buf_wr_idx = out_head_reg ^ out_cnt_reg[0];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:   if (bus.pwr_sleep_req) state_next = issue ? ST_DRAIN : ST_RET;
            ST_DRAIN: state_next = ST_RET;
            ST_RET:   if (!bus.pwr_sleep_req) state_next = ST_WAKE;
            ST_WAKE:  if (wake_done) state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_reg    <= ST_RUN;
            wptr_reg     <= 8'd0;
            rptr_reg     <= 8'd0;
            count_reg    <= 9'd0;
            inflight_reg <= 1'b0;
            out_cnt_reg  <= 2'd0;
            out_head_reg <= 1'b0;
            wake_cnt_reg <= 4'd0;
            wr_prdy_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wptr_reg     <= wptr_reg + {7'd0, push};
            rptr_reg     <= rptr_reg + {7'd0, issue};
            count_reg    <= count_next;
            inflight_reg <= issue;
            out_cnt_reg  <= out_cnt_next;
            out_head_reg <= out_head_reg ^ pop;
            wake_cnt_reg <= (state_reg == ST_WAKE) ? wake_cnt_reg + 4'd1 : 4'd0;
            wr_prdy_reg  <= (state_next == ST_RUN) && (count_next != 9'd256);
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_out_buf
            logic [7:0] data_reg;

            always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
                if (!nvdla_core_rstn) begin
                    data_reg <= 8'd0;
                end else if (capture && (buf_wr_idx == 1'(gi))) begin
                    data_reg <= bus.ram_rd;
                end
            end

            assign buf_data[gi] = data_reg;
        end
    endgenerate

    assign bus.wr_prdy       = wr_prdy_reg;
    assign bus.rd_pvld       = (out_cnt_reg != 2'd0);
    assign bus.rd_pd         = buf_data[out_head_reg];
    assign bus.ram_re        = issue;
    assign bus.ram_ra        = rptr_reg;
    assign bus.ram_we        = push;
    assign bus.ram_wa        = wptr_reg;
    assign bus.ram_wd        = push ? bus.wr_pd : 8'd0;
    assign bus.ram_sleep_en  = (state_reg == ST_RET) ? 8'hFF : 8'h00;
    assign bus.ram_ret_en    = (state_reg == ST_RET);
    assign bus.pwr_sleep_ack = (state_reg == ST_RET);
    assign bus.ram_count     = count_reg;

endmodule

// File: tb/tb_ram_256x8_fifo_ctrl.sv
// Randomized bench for ram_256x8_fifo_ctrl: behavioural RAM bank plus a byte-queue
// reference model of the FIFO contents, checked on every pop.
module tb_ram_256x8_fifo_ctrl;

    logic clk;
    logic rstn;

    ram_256x8_fifo_ctrl_if bus ();

    ram_256x8_fifo_ctrl #(.WAKE_CYC(2)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 256x8 bank: write and registered read on the rising edge.
    logic [7:0] ram_mem [256];
    logic [7:0] ram_rd_q;
    always @(posedge clk) begin
        if (bus.ram_we) ram_mem[bus.ram_wa] <= bus.ram_wd;
        if (bus.ram_re) ram_rd_q <= ram_mem[bus.ram_ra];
    end
    assign bus.ram_rd = ram_rd_q;

    int tests_run    = 0;
    int tests_failed = 0;
    int pops         = 0;
    int wr_total     = 0;
    logic [7:0] model_q [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: pops compared before the same-cycle push is queued.
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.rd_pvld && bus.rd_prdy) begin
                pops++;
                check_val("rd_nonempty", 32'(model_q.size() != 0), 32'd1);
                if (model_q.size() != 0) begin
                    logic [7:0] exp_b;
                    exp_b = model_q.pop_front();
                    check_val("rd_data", 32'(bus.rd_pd), 32'(exp_b));
                end
            end
            if (bus.wr_pvld && bus.wr_prdy) begin
                model_q.push_back(bus.wr_pd);
                wr_total++;
            end
            if (bus.ram_ret_en) check_val("ret_no_strobe", {30'd0, bus.ram_re, bus.ram_we}, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        bus.wr_pvld = 1'b1;
        bus.wr_pd   = d;
        for (int i = 0; i < 400; i++) begin
            sample();
            if (bus.wr_prdy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check_val("push_timeout", 32'(ok), 32'd1);
        tick();
        bus.wr_pvld = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit done;
        done = 1'b0;
        bus.rd_prdy = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            sample();
            if (model_q.size() == 0 && !bus.rd_pvld) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check_val({tag, "_drained"}, 32'(done), 32'd1);
        check_val({tag, "_count0"}, 32'(bus.ram_count), 32'd0);
        tick();
        bus.rd_prdy = 1'b0;
    endtask

    task automatic run_random(input int n_bytes, input int max_cycles);
        int sent;
        sent = 0;
        for (int cyc = 0; cyc < max_cycles && sent < n_bytes; cyc++) begin
            bus.wr_pvld = (sent < n_bytes) && ($urandom_range(0, 3) != 0);
            bus.wr_pd   = 8'($urandom);
            bus.rd_prdy = 1'($urandom_range(0, 1));
            sample();
            if (bus.wr_pvld && bus.wr_prdy) sent++;
            tick();
        end
        bus.wr_pvld = 1'b0;
        bus.rd_prdy = 1'b0;
        check_val("random_sent", 32'(sent), 32'(n_bytes));
    endtask

    initial begin
        int p0;
        logic [7:0] exp_addr;

        rstn              = 1'b0;
        bus.wr_pvld       = 1'b1;
        bus.wr_pd         = 8'hFF;
        bus.rd_prdy       = 1'b0;
        bus.pwr_sleep_req = 1'b0;

        // Reset state, with a write offered while in reset
        repeat (3) @(posedge clk);
        sample();
        check_val("rst_flags", {26'd0, bus.wr_prdy, bus.rd_pvld, bus.ram_re, bus.ram_we,
                                bus.ram_ret_en, bus.pwr_sleep_ack}, 32'd0);
        check_val("rst_rd_pd", 32'(bus.rd_pd), 32'd0);
        check_val("rst_count", 32'(bus.ram_count), 32'd0);
        check_val("rst_wd_sleep", {16'd0, bus.ram_wd, bus.ram_sleep_en}, 32'd0);
        check_val("rst_addr", {16'd0, bus.ram_wa, bus.ram_ra}, 32'd0);
        bus.wr_pvld = 1'b0;
        rstn        = 1'b1;
        tick();
        sample();
        check_val("prdy_after_rst", 32'(bus.wr_prdy), 32'd1);
        tick();

        // Basic ordering
        for (int i = 0; i < 10; i++) push_byte(8'(i));
        sample(); tick(); sample();
        check_val("basic_count", 32'(bus.ram_count), 32'd8);
        check_val("basic_pvld", 32'(bus.rd_pvld), 32'd1);
        check_val("basic_head", 32'(bus.rd_pd), 32'h00);
        tick();
        p0 = pops;
        bus.rd_prdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sample();
            tick();
        end
        check_val("basic_pop_rate", 32'(pops - p0), 32'd10);
        drain("basic");

        // Full and wrap
        for (int i = 0; i < 258; i++) push_byte(8'($urandom));
        sample();
        check_val("full_prdy", 32'(bus.wr_prdy), 32'd0);
        check_val("full_count", 32'(bus.ram_count), 32'd256);
        tick();
        bus.rd_prdy = 1'b1;
        sample();
        check_val("full_pop_pvld", 32'(bus.rd_pvld), 32'd1);
        tick();
        bus.rd_prdy = 1'b0;
        sample();
        check_val("full_prdy_back", 32'(bus.wr_prdy), 32'd1);
        tick();
        run_random(600, 20000);
        drain("wrap");

        // Empty-to-output latency
        bus.rd_prdy = 1'b1;
        bus.wr_pvld = 1'b1;
        bus.wr_pd   = 8'hA5;
        exp_addr    = 8'(wr_total);
        sample();
        check_val("lat_we", {31'd0, bus.ram_we}, 32'd1);
        check_val("lat_wa", 32'(bus.ram_wa), 32'(exp_addr));
        tick();
        bus.wr_pvld = 1'b0;
        sample();
        check_val("lat_re", {31'd0, bus.ram_re}, 32'd1);
        check_val("lat_ra", 32'(bus.ram_ra), 32'(exp_addr));
        check_val("lat_pvld_early", 32'(bus.rd_pvld), 32'd0);
        tick(); sample();
        check_val("lat_pvld_inflight", 32'(bus.rd_pvld), 32'd0);
        tick(); sample();
        check_val("lat_pvld", 32'(bus.rd_pvld), 32'd1);
        check_val("lat_pd", 32'(bus.rd_pd), 32'hA5);
        tick();
        drain("lat");

        // Retention with nothing in flight
        for (int i = 0; i < 100; i++) push_byte(8'($urandom));
        sample(); tick(); sample();
        check_val("ret_pre_count", 32'(bus.ram_count), 32'd98);
        tick();
        p0 = pops;
        bus.pwr_sleep_req = 1'b1;
        sample();
        check_val("ret_ack_early", 32'(bus.pwr_sleep_ack), 32'd0);
        tick();
        bus.wr_pvld = 1'b1;
        bus.wr_pd   = 8'h77;
        sample();
        check_val("ret_ack", 32'(bus.pwr_sleep_ack), 32'd1);
        check_val("ret_en", 32'(bus.ram_ret_en), 32'd1);
        check_val("ret_sleep_en", 32'(bus.ram_sleep_en), 32'hFF);
        check_val("ret_wr_prdy", 32'(bus.wr_prdy), 32'd0);
        repeat (3) begin
            tick();
            sample();
        end
        check_val("ret_hold_count", 32'(bus.ram_count), 32'd98);
        tick();
        bus.wr_pvld       = 1'b0;
        bus.pwr_sleep_req = 1'b0;
        sample();
        check_val("wake_ack_hold", 32'(bus.pwr_sleep_ack), 32'd1);
        tick(); sample();
        check_val("wake_flags", {29'd0, bus.ram_ret_en, bus.pwr_sleep_ack, bus.wr_prdy}, 32'd0);
        check_val("wake_sleep_en", 32'(bus.ram_sleep_en), 32'd0);
        tick(); sample();
        check_val("wake_prdy_c2", 32'(bus.wr_prdy), 32'd0);
        tick(); sample();
        check_val("wake_prdy_c3", 32'(bus.wr_prdy), 32'd1);
        tick();
        drain("ret");
        check_val("ret_pops", 32'(pops - p0), 32'd100);

        // Sleep request in the same cycle as a read issue
        for (int i = 0; i < 5; i++) push_byte(8'($urandom));
        sample(); tick(); sample();
        check_val("fl_pre_count", 32'(bus.ram_count), 32'd3);
        tick();
        bus.rd_prdy       = 1'b1;
        bus.pwr_sleep_req = 1'b1;
        sample();
        check_val("fl_issue", {31'd0, bus.ram_re}, 32'd1);
        tick();
        bus.rd_prdy = 1'b0;
        sample();
        check_val("fl_ack_c1", 32'(bus.pwr_sleep_ack), 32'd0);
        tick(); sample();
        check_val("fl_ack_c2", 32'(bus.pwr_sleep_ack), 32'd1);
        check_val("fl_count", 32'(bus.ram_count), 32'd2);
        tick();
        p0 = pops;
        bus.rd_prdy = 1'b1;
        repeat (4) begin
            sample();
            tick();
        end
        bus.rd_prdy = 1'b0;
        sample();
        check_val("fl_ret_pops", 32'(pops - p0), 32'd2);
        check_val("fl_ret_empty", {30'd0, bus.rd_pvld, bus.pwr_sleep_ack}, 32'd1);
        tick();
        bus.pwr_sleep_req = 1'b0;
        drain("fl");

        // Asynchronous reset mid-stream
        run_random(40, 2000);
        bus.wr_pvld = 1'b1;
        bus.wr_pd   = 8'h5A;
        bus.rd_prdy = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        check_val("mid_rst_flags", {26'd0, bus.wr_prdy, bus.rd_pvld, bus.ram_re, bus.ram_we,
                                    bus.ram_ret_en, bus.pwr_sleep_ack}, 32'd0);
        check_val("mid_rst_data", {8'd0, bus.rd_pd, bus.ram_wd, bus.ram_sleep_en}, 32'd0);
        check_val("mid_rst_count", 32'(bus.ram_count), 32'd0);
        model_q.delete();
        wr_total    = 0;
        bus.wr_pvld = 1'b0;
        bus.rd_prdy = 1'b0;
        repeat (2) sample();
        rstn = 1'b1;
        tick();
        bus.wr_pvld = 1'b1;
        bus.wr_pd   = 8'h3C;
        sample();
        check_val("post_rst_we", {31'd0, bus.ram_we}, 32'd1);
        check_val("post_rst_wa", 32'(bus.ram_wa), 32'd0);
        tick();
        bus.wr_pvld = 1'b0;
        p0 = pops;
        drain("post_rst");
        check_val("post_rst_pops", 32'(pops - p0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
